ir_fetch_unit: RTL and testbench
================================

Name: ir_fetch_unit

Overview:
Instruction fetch stage directly upstream of the multicycle CPU controller. Owns the PC and issues word reads to instruction memory over a req/ready + rvalid handshake. Latches the returned word into the instruction register and drives the controller's I and W_IR_valid inputs. Takes write_ir, write_pc and the next-PC value back from the controller/datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
PC_STEP, 4, PC increment applied on each accepted fetch request.
TIMEOUT_CYCLES, 255, fetch watchdog limit in cycles; used only with FETCH_TIMEOUT_EN.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
write_ir  in  1  controller request to fetch the next instruction (single-cycle pulse).
write_pc  in  1  load pc_in into PC.
pc_in  in  32  next PC from the datapath.
imem_req  out  1  read request valid.
imem_addr  out  32  word read address (= PC).
imem_ready  in  1  memory accepts the request this cycle.
imem_rvalid  in  1  read data valid.
imem_rdata  in  32  read data.
I  out  32  instruction register contents, to the controller.
W_IR_valid  out  1  I holds a freshly fetched, valid instruction.
pc  out  32  current PC.
fetch_cnt  out  32  number of completed fetches.
fetch_err  out  1  sticky fetch timeout flag.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = BOOT, pc = RESET_PC, I = 0, W_IR_valid = 0.
  - imem_req = 0, imem_addr = RESET_PC, fetch_cnt = 0, fetch_err = 0.
- Reset asserted mid-fetch aborts the transaction immediately. Late imem_rvalid after reset release is ignored unless the unit is in WAIT.
- FSM states: BOOT, REQ, WAIT, HOLD.
  - BOOT: one cycle after reset release, unconditionally goes to REQ. This auto-fetches the first instruction.
  - REQ: imem_req = 1 and imem_addr = pc, both registered and stable until accepted. W_IR_valid = 0.
    - On imem_ready = 1, the request is accepted and pc <= pc + PC_STEP (32-bit modulo; 0xFFFF_FFFC wraps to 0).
    - Accepted with imem_rvalid = 0: go to WAIT.
    - Accepted with imem_rvalid = 1 in the same cycle (zero-wait memory): capture immediately and go to HOLD.
  - WAIT: imem_req = 0. On imem_rvalid = 1, go to HOLD.
  - Capture (entering HOLD): I <= imem_rdata, W_IR_valid <= 1 (visible the cycle after rvalid), fetch_cnt <= fetch_cnt + 1 (wraps).
  - HOLD: I and W_IR_valid held. On write_ir = 1, W_IR_valid <= 0 and go to REQ next cycle, with I unchanged until the next capture.
- write_ir in BOOT, REQ or WAIT is ignored (no queuing).
- write_pc is honoured in any state: pc <= {pc_in[31:2], 2'b00}.
  - Same cycle as a REQ acceptance: write_pc wins over the increment.
  - In REQ before acceptance: the outstanding imem_addr is not changed. The new pc applies to the next request.
- Latency: with zero-wait memory, write_ir at cycle t gives imem_req at t+1, and W_IR_valid = 1 at t+2 if ready and rvalid are both high at t+1.
- imem_rvalid outside WAIT, or outside a REQ acceptance, is ignored.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - An 8..32-bit watchdog clears on entering REQ and counts each cycle spent in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES: fetch_err <= 1 (sticky until rst), I <= 32'hE1A0_0000 (NOP), W_IR_valid <= 1, go to HOLD.
  - fetch_cnt is not incremented on a timeout.
  - A later imem_rvalid for the abandoned request is ignored.
- Not defined: no counter; fetch_err is tied to 0; the unit waits indefinitely.

Test Plan:
1. Reset release, memory ready and rvalid immediate, imem_rdata = 32'hE3A01005 -> imem_addr = 0 at cycle 2; I = 32'hE3A01005, W_IR_valid = 1 at cycle 3; pc = 4; fetch_cnt = 1.
2. In HOLD, pulse write_ir; ready after 3 cycles, rvalid 2 cycles later -> imem_req held high 4 cycles with addr 4; W_IR_valid low throughout; I captured one cycle after rvalid; pc = 8.
3. write_pc = 1, pc_in = 32'h0000_0103, in the same cycle as REQ acceptance -> pc = 32'h0000_0100, not incremented; next request addr = 0x100.
4. RESET_PC = 32'hFFFF_FFFC, one fetch -> pc wraps to 0; extra write_ir pulses during WAIT are ignored (exactly one capture).
5. rst asserted during WAIT, then rvalid arrives -> all outputs at reset values, rvalid ignored, BOOT refetches from RESET_PC.
6. With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES = 10, memory never ready -> after 10 cycles fetch_err = 1, I = 32'hE1A00000, W_IR_valid = 1, fetch_cnt unchanged.

Source files
------------

// File: rtl/ir_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory and feeds the controller's IR.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module ir_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic [31:0] PC_STEP        = 32'd4,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_ir,
    input  logic        write_pc,
    input  logic [31:0] pc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] I,
    output logic        W_IR_valid,
    output logic [31:0] pc,
    output logic [31:0] fetch_cnt,
    output logic        fetch_err
);

    typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        capture;
    logic        timeout;
    logic        enter_req;
    logic [31:0] pc_aligned;
    logic        unused_bits;

    assign pc_aligned = {pc_in[31:2], 2'b00};

`ifdef FETCH_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        wd_expired;

    assign wd_expired = (wd_cnt == TIMEOUT_CYCLES - 32'd1);
    assign unused_bits = ^pc_in[1:0];
`else
    assign unused_bits = ^{pc_in[1:0], (TIMEOUT_CYCLES != 32'd0)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        capture    = 1'b0;
        timeout    = 1'b0;
        case (state)
            BOOT: next_state = REQ;
            REQ: begin
                if (imem_ready) begin
                    accept = 1'b1;
                    if (imem_rvalid) begin
                        capture    = 1'b1;
                        next_state = HOLD;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (write_ir) begin
                    next_state = REQ;
                end
            end
            default: next_state = BOOT;
        endcase
`ifdef FETCH_TIMEOUT_EN
        // A real capture on the expiry cycle takes priority over the watchdog.
        if ((state == REQ || state == WAIT) && !capture && wd_expired) begin
            timeout    = 1'b1;
            next_state = HOLD;
        end
`endif
        enter_req = (next_state == REQ) && (state != REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            I          <= 32'd0;
            W_IR_valid <= 1'b0;
            fetch_cnt  <= 32'd0;
        end else begin
            if (write_pc) begin
                pc <= pc_aligned;
            end else if (accept) begin
                pc <= pc + PC_STEP;
            end

            // The request address is snapshotted on entry so a write_pc while waiting only affects the next fetch.
            if (enter_req) begin
                imem_req  <= 1'b1;
                imem_addr <= pc;
            end else if (accept || timeout) begin
                imem_req <= 1'b0;
            end

            if (capture) begin
                I          <= imem_rdata;
                W_IR_valid <= 1'b1;
                fetch_cnt  <= fetch_cnt + 32'd1;
            end else if (timeout) begin
                I          <= NOP_INSTR;
                W_IR_valid <= 1'b1;
            end else if (state == HOLD && write_ir) begin
                W_IR_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt    <= 32'd0;
            fetch_err <= 1'b0;
        end else begin
            if (enter_req) begin
                wd_cnt <= 32'd0;
            end else if (state == REQ || state == WAIT) begin
                wd_cnt <= wd_cnt + 32'd1;
            end
            if (timeout) begin
                fetch_err <= 1'b1;
            end
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Directed testbench for ir_fetch_unit: instance a uses default parameters,
// instance b starts at 0xFFFF_FFFC with a 10-cycle watchdog.
module tb_ir_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        a_rst = 1'b1, a_write_ir = 1'b0, a_write_pc = 1'b0, a_ready = 1'b0, a_rvalid = 1'b0;
    logic [31:0] a_pc_in = 32'd0, a_rdata = 32'd0;
    logic        a_req, a_valid, a_err;
    logic [31:0] a_addr, a_I, a_pc, a_cnt;

    logic        b_rst = 1'b1, b_write_ir = 1'b0, b_write_pc = 1'b0, b_ready = 1'b0, b_rvalid = 1'b0;
    logic [31:0] b_pc_in = 32'd0, b_rdata = 32'd0;
    logic        b_req, b_valid, b_err;
    logic [31:0] b_addr, b_I, b_pc, b_cnt;

    ir_fetch_unit dut_a (
        .clk(clk), .rst(a_rst), .write_ir(a_write_ir), .write_pc(a_write_pc), .pc_in(a_pc_in),
        .imem_req(a_req), .imem_addr(a_addr), .imem_ready(a_ready), .imem_rvalid(a_rvalid),
        .imem_rdata(a_rdata), .I(a_I), .W_IR_valid(a_valid), .pc(a_pc), .fetch_cnt(a_cnt),
        .fetch_err(a_err)
    );

    ir_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4), .TIMEOUT_CYCLES(32'd10)) dut_b (
        .clk(clk), .rst(b_rst), .write_ir(b_write_ir), .write_pc(b_write_pc), .pc_in(b_pc_in),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ready(b_ready), .imem_rvalid(b_rvalid),
        .imem_rdata(b_rdata), .I(b_I), .W_IR_valid(b_valid), .pc(b_pc), .fetch_cnt(b_cnt),
        .fetch_err(b_err)
    );

    task automatic test_reset;
        a_rst = 1'b1; b_rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (a_pc !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h want %h", a_pc, 32'd0); end
        n_cmp++; if (a_I !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_I: got %h want %h", a_I, 32'd0); end
        n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b want 0", a_valid); end
        n_cmp++; if (a_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b want 0", a_req); end
        n_cmp++; if (a_addr !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_addr: got %h want 0", a_addr); end
        n_cmp++; if (a_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d want 0", a_cnt); end
        n_cmp++; if (a_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0", a_err); end
        n_cmp++; if (b_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL reset_addr_b: got %h want fffffffc", b_addr); end
    endtask

    task automatic test_first_fetch;
        a_ready = 1'b1; a_rvalid = 1'b1; a_rdata = 32'hE3A0_1005;
        a_rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_req !== 1'b1 || a_addr !== 32'd0) begin n_fail++; $display("[TB] FAIL boot_req: got req=%b addr=%h want req=1 addr=0", a_req, a_addr); end
        n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL boot_valid: got %b want 0", a_valid); end
        @(negedge clk);
        a_ready = 1'b0; a_rvalid = 1'b0;
        n_cmp++; if (a_I !== 32'hE3A0_1005 || a_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL first_capture: got I=%h v=%b want e3a01005 v=1", a_I, a_valid); end
        n_cmp++; if (a_pc !== 32'd4 || a_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL first_pc_cnt: got pc=%h cnt=%0d want 4 1", a_pc, a_cnt); end
        n_cmp++; if (a_req !== 1'b0) begin n_fail++; $display("[TB] FAIL first_req_drop: got %b want 0", a_req); end
        // A stray rvalid while holding must not disturb the instruction register.
        a_rvalid = 1'b1; a_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        a_rvalid = 1'b0;
        n_cmp++; if (a_I !== 32'hE3A0_1005 || a_cnt !== 32'd1 || a_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_stray_rvalid: got I=%h cnt=%0d v=%b want e3a01005 1 1", a_I, a_cnt, a_valid); end
    endtask

    task automatic test_stalled_fetch;
        a_write_ir = 1'b1;
        @(negedge clk);
        a_write_ir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (a_req !== 1'b1 || a_addr !== 32'd4 || a_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_req[%0d]: got req=%b addr=%h v=%b want 1 4 0", i, a_req, a_addr, a_valid); end
            if (i == 3) a_ready = 1'b1;
            @(negedge clk);
        end
        a_ready = 1'b0;
        n_cmp++; if (a_req !== 1'b0 || a_pc !== 32'd8 || a_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_accept: got req=%b pc=%h v=%b want 0 8 0", a_req, a_pc, a_valid); end
        @(negedge clk);
        n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_wait_valid: got %b want 0", a_valid); end
        a_rvalid = 1'b1; a_rdata = 32'hE081_1002;
        @(negedge clk);
        a_rvalid = 1'b0;
        n_cmp++; if (a_I !== 32'hE081_1002 || a_valid !== 1'b1 || a_cnt !== 32'd2) begin n_fail++; $display("[TB] FAIL stall_capture: got I=%h v=%b cnt=%0d want e0811002 1 2", a_I, a_valid, a_cnt); end
    endtask

    task automatic test_write_pc;
        a_write_ir = 1'b1;
        @(negedge clk);
        a_write_ir = 1'b0;
        n_cmp++; if (a_req !== 1'b1 || a_addr !== 32'd8) begin n_fail++; $display("[TB] FAIL wpc_req: got req=%b addr=%h want 1 8", a_req, a_addr); end
        a_ready = 1'b1; a_write_pc = 1'b1; a_pc_in = 32'h0000_0103;
        @(negedge clk);
        a_ready = 1'b0; a_write_pc = 1'b0;
        n_cmp++; if (a_pc !== 32'h0000_0100 || a_req !== 1'b0) begin n_fail++; $display("[TB] FAIL wpc_on_accept: got pc=%h req=%b want 00000100 0", a_pc, a_req); end
        a_rvalid = 1'b1; a_rdata = 32'hE280_0001;
        @(negedge clk);
        a_rvalid = 1'b0;
        n_cmp++; if (a_valid !== 1'b1 || a_cnt !== 32'd3) begin n_fail++; $display("[TB] FAIL wpc_capture: got v=%b cnt=%0d want 1 3", a_valid, a_cnt); end
        a_write_ir = 1'b1;
        @(negedge clk);
        a_write_ir = 1'b0;
        n_cmp++; if (a_addr !== 32'h0000_0100 || a_req !== 1'b1) begin n_fail++; $display("[TB] FAIL wpc_next_addr: got addr=%h req=%b want 00000100 1", a_addr, a_req); end
        a_write_pc = 1'b1; a_pc_in = 32'h0000_0202;
        @(negedge clk);
        a_write_pc = 1'b0;
        n_cmp++; if (a_addr !== 32'h0000_0100 || a_pc !== 32'h0000_0200) begin n_fail++; $display("[TB] FAIL wpc_in_req: got addr=%h pc=%h want 00000100 00000200", a_addr, a_pc); end
        a_ready = 1'b1; a_rvalid = 1'b1; a_rdata = 32'hE150_0002;
        @(negedge clk);
        a_ready = 1'b0; a_rvalid = 1'b0;
        n_cmp++; if (a_pc !== 32'h0000_0204 || a_I !== 32'hE150_0002 || a_cnt !== 32'd4) begin n_fail++; $display("[TB] FAIL wpc_after: got pc=%h I=%h cnt=%0d want 00000204 e1500002 4", a_pc, a_I, a_cnt); end
    endtask

    task automatic test_back_to_back;
        a_ready = 1'b1; a_rvalid = 1'b1; a_rdata = 32'hEAFF_FFFE; a_write_ir = 1'b1;
        @(negedge clk);
        a_write_ir = 1'b0;
        n_cmp++; if (a_req !== 1'b1 || a_valid !== 1'b0 || a_addr !== 32'h0000_0204) begin n_fail++; $display("[TB] FAIL b2b_t1: got req=%b v=%b addr=%h want 1 0 00000204", a_req, a_valid, a_addr); end
        @(negedge clk);
        n_cmp++; if (a_valid !== 1'b1 || a_I !== 32'hEAFF_FFFE || a_pc !== 32'h0000_0208 || a_cnt !== 32'd5) begin n_fail++; $display("[TB] FAIL b2b_t2: got v=%b I=%h pc=%h cnt=%0d want 1 eafffffe 00000208 5", a_valid, a_I, a_pc, a_cnt); end
        a_write_ir = 1'b1; a_rdata = 32'hE3A0_0000;
        @(negedge clk);
        a_write_ir = 1'b0;
        n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_second_t1: got v=%b want 0", a_valid); end
        @(negedge clk);
        a_ready = 1'b0; a_rvalid = 1'b0;
        n_cmp++; if (a_valid !== 1'b1 || a_I !== 32'hE3A0_0000 || a_pc !== 32'h0000_020C || a_cnt !== 32'd6) begin n_fail++; $display("[TB] FAIL b2b_second_t2: got v=%b I=%h pc=%h cnt=%0d want 1 e3a00000 0000020c 6", a_valid, a_I, a_pc, a_cnt); end
    endtask

    task automatic test_reset_mid_fetch;
        a_write_ir = 1'b1;
        @(negedge clk);
        a_write_ir = 1'b0; a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        n_cmp++; if (a_req !== 1'b0 || a_pc !== 32'h0000_0210) begin n_fail++; $display("[TB] FAIL mid_wait: got req=%b pc=%h want 0 00000210", a_req, a_pc); end
        a_rst = 1'b1;
        #1;
        n_cmp++; if (a_pc !== 32'd0 || a_I !== 32'd0 || a_valid !== 1'b0 || a_req !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_async: got pc=%h I=%h v=%b req=%b want 0 0 0 0", a_pc, a_I, a_valid, a_req); end
        n_cmp++; if (a_addr !== 32'd0 || a_cnt !== 32'd0 || a_err !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_regs: got addr=%h cnt=%0d err=%b want 0 0 0", a_addr, a_cnt, a_err); end
        a_rvalid = 1'b1; a_rdata = 32'hBADB_AD00;
        @(negedge clk);
        a_rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_req !== 1'b1 || a_addr !== 32'd0 || a_valid !== 1'b0 || a_I !== 32'd0 || a_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL mid_late_rvalid: got req=%b addr=%h v=%b I=%h cnt=%0d want 1 0 0 0 0", a_req, a_addr, a_valid, a_I, a_cnt); end
        a_ready = 1'b1; a_rdata = 32'hE3A0_1005;
        @(negedge clk);
        a_ready = 1'b0; a_rvalid = 1'b0;
        n_cmp++; if (a_I !== 32'hE3A0_1005 || a_valid !== 1'b1 || a_pc !== 32'd4 || a_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL mid_refetch: got I=%h v=%b pc=%h cnt=%0d want e3a01005 1 4 1", a_I, a_valid, a_pc, a_cnt); end
    endtask

    task automatic test_pc_wrap;
        b_rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (b_req !== 1'b1 || b_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_req: got req=%b addr=%h want 1 fffffffc", b_req, b_addr); end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        n_cmp++; if (b_pc !== 32'd0 || b_req !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_pc: got pc=%h req=%b want 0 0", b_pc, b_req); end
        b_write_ir = 1'b1;
        repeat (2) @(negedge clk);
        b_write_ir = 1'b0;
        n_cmp++; if (b_valid !== 1'b0 || b_req !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_wait_ir: got v=%b req=%b want 0 0", b_valid, b_req); end
        b_rvalid = 1'b1; b_rdata = 32'hE1A0_F00E;
        @(negedge clk);
        b_rvalid = 1'b0;
        n_cmp++; if (b_I !== 32'hE1A0_F00E || b_valid !== 1'b1 || b_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL wrap_capture: got I=%h v=%b cnt=%0d want e1a0f00e 1 1", b_I, b_valid, b_cnt); end
        repeat (3) @(negedge clk);
        n_cmp++; if (b_cnt !== 32'd1 || b_req !== 1'b0 || b_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_no_queue: got cnt=%0d req=%b v=%b want 1 0 1", b_cnt, b_req, b_valid); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout;
        b_write_ir = 1'b1;
        @(negedge clk);
        b_write_ir = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if ({b_valid, b_err} !== 2'b00) begin n_fail++; $display("[TB] FAIL to_early[%0d]: got v=%b err=%b want 0 0", i, b_valid, b_err); end
        end
        @(negedge clk);
        n_cmp++; if (b_err !== 1'b1 || b_I !== 32'hE1A0_0000 || b_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL to_fire: got err=%b I=%h v=%b want 1 e1a00000 1", b_err, b_I, b_valid); end
        n_cmp++; if (b_cnt !== 32'd1 || b_req !== 1'b0) begin n_fail++; $display("[TB] FAIL to_cnt: got cnt=%0d req=%b want 1 0", b_cnt, b_req); end
        b_rvalid = 1'b1; b_rdata = 32'h1234_5678;
        @(negedge clk);
        b_rvalid = 1'b0;
        n_cmp++; if (b_I !== 32'hE1A0_0000 || b_cnt !== 32'd1) begin n_fail++; $display("[TB] FAIL to_late_rvalid: got I=%h cnt=%0d want e1a00000 1", b_I, b_cnt); end
        b_write_ir = 1'b1;
        @(negedge clk);
        b_write_ir = 1'b0; b_ready = 1'b1; b_rvalid = 1'b1; b_rdata = 32'hE3A0_2007;
        n_cmp++; if (b_addr !== 32'd0) begin n_fail++; $display("[TB] FAIL to_retry_addr: got %h want 0", b_addr); end
        @(negedge clk);
        b_ready = 1'b0; b_rvalid = 1'b0;
        n_cmp++; if (b_I !== 32'hE3A0_2007 || b_cnt !== 32'd2 || b_err !== 1'b1) begin n_fail++; $display("[TB] FAIL to_sticky: got I=%h cnt=%0d err=%b want e3a02007 2 1", b_I, b_cnt, b_err); end
    endtask
`else
    task automatic test_timeout;
        b_write_ir = 1'b1;
        @(negedge clk);
        b_write_ir = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            n_cmp++; if ({b_req, b_valid, b_err} !== 3'b100) begin n_fail++; $display("[TB] FAIL nowd_wait[%0d]: got req=%b v=%b err=%b want 1 0 0", i, b_req, b_valid, b_err); end
        end
        b_ready = 1'b1; b_rvalid = 1'b1; b_rdata = 32'hE3A0_2007;
        @(negedge clk);
        b_ready = 1'b0; b_rvalid = 1'b0;
        n_cmp++; if (b_I !== 32'hE3A0_2007 || b_cnt !== 32'd2 || b_err !== 1'b0) begin n_fail++; $display("[TB] FAIL nowd_capture: got I=%h cnt=%0d err=%b want e3a02007 2 0", b_I, b_cnt, b_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_fetch();
        test_stalled_fetch();
        test_write_pc();
        test_back_to_back();
        test_reset_mid_fetch();
        test_pc_wrap();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got stuck want done");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
